// File: rtl/matrix_pkg.sv
// Shared types and defaults for the HUB75 matrix scan scheduler and column shifter.
package matrix_pkg;

  localparam int unsigned SCAN_BIT_DEF = 3;
  localparam int unsigned BITDEPTH_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_BLANK,
    S_LATCH,
    S_SHOW,
    S_WAIT
  } sched_state_t;

  // Binary-code-modulation on-time of a plane, in clk cycles.
  function automatic int unsigned show_ticks(input int unsigned base, input int unsigned plane);
    return base << plane;
  endfunction

endpackage

// File: rtl/matrix_scan_index.sv
// Next (line, plane) index: planes 0..bitdepth-1 within a line, then the next line.
module matrix_scan_index
  import matrix_pkg::*;
#(
  parameter int unsigned bitdepth = BITDEPTH_DEF,
  parameter int unsigned scan_bit = SCAN_BIT_DEF,
  localparam int unsigned PW = (bitdepth > 1) ? $clog2(bitdepth) : 1
) (
  input  logic                clk,
  input  logic                reset_b,
  input  logic                clear,
  input  logic                advance,
  output logic [scan_bit-1:0] idx_line,
  output logic [PW-1:0]       idx_plane
);

  localparam logic [PW-1:0] LAST_PLANE = PW'(bitdepth - 1);

  logic [scan_bit-1:0] line_d;
  logic [PW-1:0]       plane_d;

  // Plane wraps at bitdepth-1 explicitly; line wraps naturally at its width.
  always_comb begin
    line_d  = idx_line;
    plane_d = idx_plane;
    if (clear) begin
      line_d  = '0;
      plane_d = '0;
    end else if (advance) begin
      if (idx_plane == LAST_PLANE) begin
        plane_d = '0;
        line_d  = idx_line + scan_bit'(1);
      end else begin
        plane_d = idx_plane + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      idx_line  <= '0;
      idx_plane <= '0;
    end else begin
      idx_line  <= line_d;
      idx_plane <= plane_d;
    end
  end

endmodule

// File: rtl/matrix_scheduler.sv
// BCM scan scheduler: overlaps the shift of the next plane with display of the current one.
module matrix_scheduler
  import matrix_pkg::*;
#(
  parameter int unsigned bitdepth    = BITDEPTH_DEF,
  parameter int unsigned scan_bit    = SCAN_BIT_DEF,
  parameter int unsigned base_ticks  = 8,
  parameter int unsigned blank_ticks = 2,
  localparam int unsigned PW = (bitdepth > 1) ? $clog2(bitdepth) : 1,
  localparam int unsigned TW = $clog2(base_ticks << (bitdepth - 1)) + 1
) (
  input  logic                clk,
  input  logic                reset_b,
  input  logic                enable,
  output logic                shift_start,
  output logic [scan_bit-1:0] shift_line,
  output logic [PW-1:0]       shift_plane,
  input  logic                shift_done,
  output logic                latch,
  output logic                oe_b,
  output logic [scan_bit-1:0] select,
  output logic                frame_start
);

  localparam logic [TW-1:0] BLANK_LOAD = TW'(blank_ticks - 1);

  sched_state_t  state, state_d;
  logic [TW-1:0] timer, timer_d;
  logic          pending, pending_d;
  logic          issued, issued_d;
  logic          show_first;
  logic [PW-1:0] cur_plane;
  logic          start_d;
  logic          idx_clear, idx_adv;
  logic          issue_now;
  logic          done_ok;

  matrix_scan_index #(
    .bitdepth (bitdepth),
    .scan_bit (scan_bit)
  ) u_index (
    .clk       (clk),
    .reset_b   (reset_b),
    .clear     (idx_clear),
    .advance   (idx_adv),
    .idx_line  (shift_line),
    .idx_plane (shift_plane)
  );

  always_comb begin
    state_d   = state;
    timer_d   = timer;
    issued_d  = issued;
    start_d   = 1'b0;
    idx_clear = 1'b0;
    idx_adv   = 1'b0;
    issue_now = 1'b0;
    done_ok   = shift_done && pending;

    case (state)
      S_IDLE: begin
        if (enable) begin
          start_d   = 1'b1;
          idx_clear = 1'b1;
          state_d   = S_FILL;
        end
      end
      S_FILL, S_WAIT: begin
        if (done_ok) begin
          state_d = S_BLANK;
          timer_d = BLANK_LOAD;
        end
      end
      S_BLANK: begin
        if (timer == '0) state_d = S_LATCH;
        else             timer_d = timer - TW'(1);
      end
      S_LATCH: begin
        state_d  = S_SHOW;
        issued_d = 1'b0;
        timer_d  = TW'(show_ticks(base_ticks, 32'(cur_plane)) - 32'd1);
      end
      S_SHOW: begin
        issue_now = show_first && enable;
        if (issue_now) begin
          start_d  = 1'b1;
          idx_adv  = 1'b1;
          issued_d = 1'b1;
        end
        // A done arriving on the final cycle counts; a shift issued this very cycle cannot be done yet.
        if (timer == '0) begin
          if (!(issued || issue_now))                    state_d = S_IDLE;
          else if (issue_now || (pending && !shift_done)) state_d = S_WAIT;
          else begin
            state_d = S_BLANK;
            timer_d = BLANK_LOAD;
          end
        end else begin
          timer_d = timer - TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    pending_d = pending;
    if (start_d)      pending_d = 1'b1;
    else if (done_ok) pending_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state       <= S_IDLE;
      timer       <= '0;
      pending     <= 1'b0;
      issued      <= 1'b0;
      show_first  <= 1'b0;
      cur_plane   <= '0;
      shift_start <= 1'b0;
      latch       <= 1'b0;
      oe_b        <= 1'b1;
      select      <= '0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_d;
      timer       <= timer_d;
      pending     <= pending_d;
      issued      <= issued_d;
      show_first  <= (state == S_LATCH);
      shift_start <= start_d;
      latch       <= (state_d == S_LATCH);
      oe_b        <= (state_d != S_SHOW);
      frame_start <= 1'b0;
      if (state_d == S_LATCH) begin
        select      <= shift_line;
        cur_plane   <= shift_plane;
        frame_start <= (shift_line == '0) && (shift_plane == '0);
      end
    end
  end

endmodule
